// File: rtl/gfx_dma_queue.sv
`timescale 1ns/1ps
// gfx_dma_queue: CPU-staged 8-byte blit descriptors, queued and replayed into gfx_dma's register port.
// Define GFX_DMA_QUEUE_IRQ_EN to add the active-low queue-drained interrupt o_irq_b.
module gfx_dma_queue #(
  parameter int unsigned DepthLog2    = 2,
  parameter int unsigned StartTimeout = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ce_b,
  input  logic       i_we_b,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_status,
  output logic       o_dma_ce_b,
  output logic       o_dma_we_b,
  output logic [2:0] o_dma_addr,
  output logic [7:0] o_dma_data,
`ifdef GFX_DMA_QUEUE_IRQ_EN
  output logic       o_irq_b,
`endif
  input  logic       i_dma_active
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam int unsigned CW    = DepthLog2 + 1;
  localparam int unsigned TW    = $clog2(StartTimeout + 1);
  localparam logic [TW-1:0] TmrLast = TW'(StartTimeout - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT_START, WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          k, k_nxt;
  logic [TW-1:0]       tmr, tmr_nxt;

  logic [7:0]          stage [8];
  logic [7:0]          mem [Depth][8];
  logic [DepthLog2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [2:0]          count_sat;
  logic                overflow, timeout_err;

  logic wr_req, wr_prev, wr_cap, commit, ctrl_wr;
  logic full, empty, push, pop, to_set, busy;

  // One capture per strobe: act only on the first cycle the write condition is seen.
  assign wr_req  = ~i_ce_b & ~i_we_b;
  assign wr_cap  = wr_req & ~wr_prev;
  assign commit  = wr_cap && (i_addr == 4'd7);
  assign ctrl_wr = wr_cap && (i_addr == 4'd8);

  assign full  = (count == CW'(Depth));
  assign empty = (count == '0);
  assign push  = commit && (!full || pop);
  assign busy  = (state != IDLE);

  assign count_sat = (32'(count) > 32'd7) ? 3'd7 : 3'(32'(count));
  assign o_status  = {busy, empty, full, overflow, timeout_err, count_sat};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_prev     <= 1'b0;
      stage       <= '{default: '0};
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wr_prev <= wr_req;
      if (wr_cap && !i_addr[3]) stage[i_addr[2:0]] <= i_data;
      if (push) wr_ptr <= wr_ptr + DepthLog2'(1);
      if (pop)  rd_ptr <= rd_ptr + DepthLog2'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (ctrl_wr) begin
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (commit && full && !pop) overflow <= 1'b1;
      if (to_set) timeout_err <= 1'b1;
    end
  end

  // Byte 7 comes straight from the bus so the commit edge stores the complete descriptor.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= '{stage[0], stage[1], stage[2], stage[3],
                               stage[4], stage[5], stage[6], i_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      k     <= '0;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    tmr_nxt    = tmr;
    pop        = 1'b0;
    to_set     = 1'b0;
    o_dma_ce_b = 1'b1;
    o_dma_we_b = 1'b1;
    o_dma_addr = '0;
    o_dma_data = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          k_nxt     = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        o_dma_ce_b = 1'b0;
        o_dma_addr = k;
        o_dma_data = mem[rd_ptr][k];
        state_nxt  = STROBE;
      end
      STROBE: begin
        o_dma_ce_b = 1'b0;
        o_dma_we_b = 1'b0;
        o_dma_addr = k;
        o_dma_data = mem[rd_ptr][k];
        state_nxt  = HOLD;
      end
      HOLD: begin
        o_dma_ce_b = 1'b0;
        o_dma_addr = k;
        o_dma_data = mem[rd_ptr][k];
        if (k == 3'd7) begin
          tmr_nxt   = '0;
          state_nxt = WAIT_START;
        end else begin
          k_nxt     = k + 3'd1;
          state_nxt = SETUP;
        end
      end
      WAIT_START: begin
        if (i_dma_active) begin
          state_nxt = WAIT_DONE;
        end else if (tmr == TmrLast) begin
          to_set    = 1'b1;
          pop       = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!i_dma_active) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GFX_DMA_QUEUE_IRQ_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)                                     o_irq_b <= 1'b1;
    else if (pop && !push && count == CW'(1))      o_irq_b <= 1'b0;
    else if (ctrl_wr || commit)                    o_irq_b <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_gfx_dma_queue.sv
`timescale 1ns/1ps
// tb_gfx_dma_queue: directed stimulus; a descriptor-queue reference model is checked every cycle,
// with hand-computed literal expectations at the key points of each scenario.
module tb_gfx_dma_queue;
  localparam int unsigned TO    = 15;
  localparam int          DEPTH = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       ce_b = 1'b1;
  logic       we_b = 1'b1;
  logic [3:0] addr = '0;
  logic [7:0] data = '0;
  logic       act  = 1'b0;
  logic [7:0] status;
  logic       dma_ce_b, dma_we_b;
  logic [2:0] dma_addr;
  logic [7:0] dma_data;
`ifdef GFX_DMA_QUEUE_IRQ_EN
  logic       irq_b;
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  gfx_dma_queue #(.DepthLog2(2), .StartTimeout(TO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ce_b      (ce_b),
    .i_we_b      (we_b),
    .i_addr      (addr),
    .i_data      (data),
    .o_status    (status),
    .o_dma_ce_b  (dma_ce_b),
    .o_dma_we_b  (dma_we_b),
    .o_dma_addr  (dma_addr),
    .o_dma_data  (dma_data),
`ifdef GFX_DMA_QUEUE_IRQ_EN
    .o_irq_b     (irq_b),
`endif
    .i_dma_active(act)
  );

  // Reference model: a queue of whole descriptors plus the elapsed-cycle position of the replay.
  typedef logic [63:0] desc_t;
  desc_t mq[$];
  desc_t m_stage = '0;
  bit    m_ovf = 0, m_tmo = 0, m_irq_b = 1, m_wprev = 0, m_busy = 0, m_seen = 0;
  int    m_cyc = 0, m_wcnt = 0;

  always @(posedge clk) begin : model
    bit wreq, cap, pop;
    int a;
    wreq = (ce_b === 1'b0) && (we_b === 1'b0);
    a    = int'(addr);
    if (rst) begin
      mq.delete();
      m_stage = '0; m_ovf = 0; m_tmo = 0; m_irq_b = 1; m_wprev = 0;
      m_busy = 0; m_seen = 0; m_cyc = 0; m_wcnt = 0;
    end else begin
      cap     = wreq && !m_wprev;
      m_wprev = wreq;
      pop     = 0;
      if (cap && a == 8) begin m_ovf = 0; m_tmo = 0; m_irq_b = 1; end
      if (cap && a == 7) m_irq_b = 1;
      if (!m_busy) begin
        if (mq.size() > 0) begin m_busy = 1; m_cyc = 0; end
      end else if (m_cyc < 23) begin
        m_cyc++;
      end else if (m_cyc == 23) begin
        m_cyc = 24; m_wcnt = 0; m_seen = 0;
      end else if (!m_seen) begin
        if (act) m_seen = 1;
        else if (m_wcnt == int'(TO) - 1) begin m_tmo = 1; pop = 1; end
        else m_wcnt++;
      end else if (!act) begin
        pop = 1;
      end
      if (cap && a < 8) m_stage[8*a +: 8] = data;
      if (pop) begin void'(mq.pop_front()); m_busy = 0; end
      if (cap && a == 7) begin
        if (mq.size() < DEPTH) mq.push_back(m_stage);
        else m_ovf = 1;
      end
      if (pop && mq.size() == 0) m_irq_b = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] e_status, e_data;
    logic [2:0] e_addr;
    logic       e_ce, e_we;
    desc_t      h;
    bit         in_bytes, bad;
    int         sz;
    if (chk_en) begin
      sz       = mq.size();
      in_bytes = m_busy && (m_cyc < 24);
      e_ce     = !in_bytes;
      e_we     = !(in_bytes && (m_cyc % 3 == 1));
      e_addr   = in_bytes ? 3'(m_cyc / 3) : 3'd0;
      e_data   = 8'h00;
      if (in_bytes) begin h = mq[0]; e_data = h[8*(m_cyc/3) +: 8]; end
      e_status = {m_busy, sz == 0, sz == DEPTH, m_ovf, m_tmo, 3'(sz)};
      bad = (status !== e_status) || (dma_ce_b !== e_ce) || (dma_we_b !== e_we) ||
            (dma_addr !== e_addr) || (dma_data !== e_data);
`ifdef GFX_DMA_QUEUE_IRQ_EN
      if (irq_b !== m_irq_b) bad = 1;
`endif
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL cycle t=%0t status %h exp %h ce_b %b exp %b we_b %b exp %b addr %0d exp %0d data %h exp %h",
                 $time, status, e_status, dma_ce_b, e_ce, dma_we_b, e_we, dma_addr, e_addr, dma_data, e_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected event within budget", name);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    ce_b = 1'b0; we_b = 1'b0; addr = a; data = d;
    step();
    ce_b = 1'b1; we_b = 1'b1;
    step();
  endtask

  logic [7:0] d1 [8] = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h05, 8'h05, 8'hff, 8'h00};
  logic [2:0] sa [8];
  logic [7:0] sd [8];
  int         nstb;
  bit         found;

  initial begin : stim
    // Reset state
    step(); step();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_status", status, 32'h40);
    check("reset_ce_b", dma_ce_b, 1);
    check("reset_we_b", dma_we_b, 1);
    check("reset_addr", dma_addr, 0);
    check("reset_data", dma_data, 0);
    rst = 1'b0;
    step();

    // Single descriptor replay; no start from gfx_dma so it times out
    for (int i = 0; i < 7; i++) cpu_wr(4'(i), d1[i]);
    ce_b = 1'b0; we_b = 1'b0; addr = 4'd7; data = d1[7];
    step();
    @(negedge clk);
    check("commit_status", status, 32'h01);
    check("commit_idle_ce_b", dma_ce_b, 1);
    ce_b = 1'b1; we_b = 1'b1;
    @(negedge clk);
    check("setup_status", status, 32'h81);
    nstb = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (dma_we_b === 1'b0) begin
        if (nstb < 8) begin sa[nstb] = dma_addr; sd[nstb] = dma_data; end
        nstb++;
      end
    end
    check("strobe_count", nstb, 8);
    for (int b = 0; b < 8; b++) begin
      check("strobe_addr", sa[b], b);
      check("strobe_data", sd[b], d1[b]);
    end
    repeat (15) @(negedge clk);
    check("last_wait_status", status, 32'h81);
    @(negedge clk);
    check("timeout_status", status, 32'h48);
    step();
    cpu_wr(4'd8, 8'h5a);
    @(negedge clk);
    check("clear_status", status, 32'h40);

    // Replay with start 3 cycles after HOLD(7), active for 400 cycles
    step();
    cpu_wr(4'd7, 8'h01);
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (dma_we_b === 1'b0 && dma_addr === 3'd7) found = 1;
    end
    if (!found) wait_fail("wait_strobe7");
    repeat (4) @(negedge clk);
    act = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      check("busy_while_active", status[7], 1);
    end
    act = 1'b0;
    @(negedge clk);
    check("done_status", status, 32'h40);
`ifdef GFX_DMA_QUEUE_IRQ_EN
    check("irq_on_drain", irq_b, 0);
    step();
    cpu_wr(4'd8, 8'h00);
    @(negedge clk);
    check("irq_cleared", irq_b, 1);
`endif

    // Five commits with no start: overflow on the fifth, every entry times out
    step();
    for (int i = 0; i < 5; i++) begin
      cpu_wr(4'd0, 8'(8'h20 + i));
      cpu_wr(4'd7, 8'h01);
      if (i == 3) begin
        @(negedge clk);
        check("fifo_full", status, 32'hA4);
        step();
      end
    end
    @(negedge clk);
    check("overflow_status", status, 32'hB4);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (status[7] === 1'b0 && status[6] === 1'b1) found = 1;
    end
    if (!found) wait_fail("wait_drain_timeouts");
    check("drained_flags", status, 32'h58);
    step();
    cpu_wr(4'd8, 8'h00);
    @(negedge clk);
    check("flags_cleared", status, 32'h40);

    // Commit into a full FIFO on the WAIT_DONE pop edge
    step();
    act = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_wr(4'd0, 8'(8'h40 + i));
      cpu_wr(4'd7, 8'h02);
    end
    found = 0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (status === 8'hA4 && dma_ce_b === 1'b1) found = 1;
    end
    if (!found) wait_fail("wait_full_waiting");
    @(negedge clk);
    ce_b = 1'b0; we_b = 1'b0; addr = 4'd7; data = 8'h03; act = 1'b0;
    @(negedge clk);
    check("commit_on_pop", status, 32'h24);
    ce_b = 1'b1; we_b = 1'b1;
    @(negedge clk);
    check("refill_replay", status, 32'hA4);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (status === 8'h48) found = 1;
    end
    if (!found) wait_fail("wait_drain_full");

    // Long strobe gives one commit; reset during SETUP of byte 3
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset2_status", status, 32'h40);
    step();
    ce_b = 1'b0; we_b = 1'b0; addr = 4'd7; data = 8'h07;
    repeat (10) step();
    ce_b = 1'b1; we_b = 1'b1;
    @(negedge clk);
    check("long_strobe_count", status, 32'h81);
    found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (dma_ce_b === 1'b0 && dma_we_b === 1'b1 && dma_addr === 3'd3) found = 1;
    end
    if (!found) wait_fail("wait_setup3");
    rst = 1'b1;
    @(negedge clk);
    check("midreset_ce_b", dma_ce_b, 1);
    check("midreset_status", status, 32'h40);
    rst = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gfx_dma_queue.md
Name: gfx_dma_queue

Overview:
- Command queue between the CPU bus and gfx_dma.
- CPU stages an 8-byte DMA descriptor: src lo/hi, dst lo/hi, width, height, mask, start/flags.
- Writing byte 7 commits the descriptor to a FIFO.
- The block replays each queued descriptor into gfx_dma's register port, one at a time, tracking o_active between commands. The CPU never has to poll the DMA before issuing the next blit.

Parameters:
- DepthLog2, 2, log2 of queue depth in descriptors (default 4 entries).
- StartTimeout, 15, i_clk cycles to wait for i_dma_active rising after the start write before abandoning the command.

Ports:
- i_clk  in  1  gfx pixel clock
- i_rst  in  1  synchronous reset, active-high
- i_ce_b  in  1  CPU chip enable, active-low
- i_we_b  in  1  CPU write strobe, active-low
- i_addr  in  4  CPU register address: 0-7 staging, 8 control/status
- i_data  in  8  CPU write data
- o_status  out  8  {busy, empty, full, overflow, timeout_err, count[2:0]}
- o_dma_ce_b  out  1  gfx_dma register chip enable
- o_dma_we_b  out  1  gfx_dma register write strobe
- o_dma_addr  out  3  gfx_dma register address
- o_dma_data  out  8  gfx_dma register data
- i_dma_active  in  1  gfx_dma o_active

Behaviour:
- Clocking: one clock (i_clk); reset is synchronous, active-high (i_rst). All state updates on rising i_clk.
- CPU write capture:
  - A write is accepted on the first i_clk edge where i_ce_b=0 and i_we_b=0 after a cycle where that condition was false (edge-detect).
  - Exactly one capture per strobe, however long the strobe is held.
- Staging and commit:
  - Addr 0-6 write the staging byte.
  - Addr 7 writes staging byte 7 and commits all 8 bytes to the FIFO tail in the same edge.
  - If the FIFO is full and no pop occurs that edge: the commit is dropped and sticky overflow is set.
  - Staging registers are not cleared by a commit, so the next descriptor may rewrite only the changed fields.
- Addr 8 write: clears overflow and timeout_err; the data value is ignored.
- count is the FIFO occupancy, 0..2^DepthLog2, saturating at 3 bits.
- FSM states: IDLE, SETUP, STROBE, HOLD, WAIT_START, WAIT_DONE.
  - IDLE: if FIFO is non-empty, set byte index k=0 and go to SETUP. busy=0 only in IDLE.
  - SETUP: o_dma_ce_b=0, o_dma_we_b=1, addr=k, data=head[k].
  - STROBE: same addr/data, o_dma_we_b=0.
  - HOLD: o_dma_we_b=1. If k<7: k++ and go to SETUP. If k=7: go to WAIT_START.
  - The 8 bytes take 24 cycles with o_dma_ce_b held low throughout. Latency from commit edge to first SETUP is 1 cycle.
  - WAIT_START: o_dma_ce_b=1.
    - If i_dma_active=1: go to WAIT_DONE.
    - If StartTimeout cycles elapse without it: set timeout_err, pop the head, go to IDLE.
  - WAIT_DONE: when i_dma_active=0, pop the head and go to IDLE. There is no timeout in this state.
- Simultaneous commit and pop on the same edge: both take effect and count is unchanged. A full FIFO accepts the commit in this case.
- Pointers are DepthLog2 bits wide and wrap modulo depth.
- The head entry is not modified while it is being replayed; a new commit writes only the tail slot.
- Reset values:
  - o_dma_ce_b=1, o_dma_we_b=1, o_dma_addr=0, o_dma_data=0.
  - FIFO empty; staging regs 0; flags 0; FSM in IDLE.
  - o_status=8'h40 (empty=1).
- Reset mid-operation: the FSM returns to IDLE and the queue is flushed. An in-flight gfx_dma transfer is not aborted; software must not reset the block while i_dma_active=1.

Optional Feature:
- Macro GFX_DMA_QUEUE_IRQ_EN.
- Defined:
  - Adds output port o_irq_b (1 bit, active-low, reset 1).
  - o_irq_b goes to 0 on the edge where a pop leaves the FIFO empty.
  - It is cleared to 1 by an addr-8 write, or by a new commit.
- Undefined: the port does not exist and there is no interrupt logic.

Test Plan:
- Reset, then write descriptor {00,00,10,10,05,05,ff,00} via addr 0-7 -> one cycle after the commit, 24-cycle replay with bytes on o_dma_addr 0..7. o_dma_we_b low exactly 8 cycles, once per byte.
- Replay a descriptor with the bench raising i_dma_active 3 cycles after HOLD(7) and holding it 400 cycles -> busy=1 throughout. After the fall, a pop occurs and o_status returns to 8'h40.
- Commit 5 descriptors with i_dma_active held 0 by the bench and StartTimeout=15 -> first replay begins. Once 4 entries sit queued, the 5th commit sets overflow. Each command times out after 15 cycles and sets timeout_err. An addr-8 write clears both flags.
- Commit into a full FIFO on the same edge that WAIT_DONE pops -> commit accepted, overflow stays 0, count stays 4.
- Hold i_ce_b=0 and i_we_b=0 for 10 cycles at addr 7 -> exactly one commit, count=1. Assert i_rst during SETUP of byte 3 -> next cycle o_dma_ce_b=1 and o_status=8'h40.
- With GFX_DMA_QUEUE_IRQ_EN defined: one descriptor completes -> o_irq_b=0 on the pop edge, and returns to 1 after an addr-8 write.
